// File: rtl/axi_lite_target_router.sv
// AXI4-Lite target router: one upstream target port fanned out to three downstream slaves by
// address decode, one transaction outstanding, with decode-error and hung-slave timeout handling.
module axi_lite_target_router #(
    parameter int unsigned SEL_LSB        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [3:0]  s_aruser,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,

    output logic [2:0]  m_awvalid,
    input  logic [2:0]  m_awready,
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_wvalid,
    input  logic [2:0]  m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [2:0]  m_bvalid,
    output logic [2:0]  m_bready,
    input  logic [5:0]  m_bresp,
    output logic [2:0]  m_arvalid,
    input  logic [2:0]  m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_aruser,
    input  logic [2:0]  m_rvalid,
    output logic [2:0]  m_rready,
    input  logic [95:0] m_rdata,
    input  logic [5:0]  m_rresp
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StWaddr = 3'd1;
    localparam logic [2:0] StWresp = 3'd2;
    localparam logic [2:0] StBresp = 3'd3;
    localparam logic [2:0] StRaddr = 3'd4;
    localparam logic [2:0] StRdata = 3'd5;
    localparam logic [2:0] StRresp = 3'd6;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    logic [2:0]    state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [3:0]    user_q, user_d;
    logic          last_rd_q, last_rd_d;
    logic [2:0]    hung_q, hung_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          wr_pend, rd_pend, grant_rd, grant_wr;
    logic [31:0]   grant_addr;
    logic [1:0]    grant_sel;
    logic [2:0]    grant_oh, sel_oh;
    logic          timeout_hit, active;

    assign wr_pend = s_awvalid & s_wvalid;
    assign rd_pend = s_arvalid;
    // On a tie the read wins unless the previous grant was also a read.
    assign grant_rd = (state_q == StIdle) && !areset && rd_pend && (!wr_pend || !last_rd_q);
    assign grant_wr = (state_q == StIdle) && !areset && wr_pend && !grant_rd;

    assign grant_addr = grant_rd ? s_araddr : s_awaddr;
    assign grant_sel  = grant_addr[SEL_LSB+1:SEL_LSB];
    assign grant_oh   = 3'b001 << grant_sel;
    assign sel_oh     = 3'b001 << sel_q;

    assign active = (state_q == StWaddr) || (state_q == StWresp) ||
                    (state_q == StRaddr) || (state_q == StRdata);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(timer_q) == TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        user_d    = user_q;
        last_rd_d = last_rd_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        timer_d   = active ? timer_q + TW'(1) : timer_q;
        // Any response from a hung port is the stale answer to an aborted access.
        hung_d    = hung_q & ~(m_bvalid | m_rvalid);

        case (state_q)
            StIdle: begin
                if (grant_rd || grant_wr) begin
                    last_rd_d = grant_rd;
                    addr_d    = grant_addr;
                    sel_d     = grant_sel;
                    timer_d   = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (grant_wr) begin
                        wdata_d = s_wdata;
                        wstrb_d = s_wstrb;
                    end else begin
                        user_d = s_aruser;
                    end
                    if (grant_sel == 2'd3 || (hung_q & grant_oh) != 3'b000) begin
                        if (grant_wr) begin
                            bresp_d = (grant_sel == 2'd3) ? RespDecerr : RespSlverr;
                            state_d = StBresp;
                        end else begin
                            rresp_d = (grant_sel == 2'd3) ? RespDecerr : RespSlverr;
                            rdata_d = '0;
                            state_d = StRresp;
                        end
                    end else begin
                        state_d = grant_wr ? StWaddr : StRaddr;
                    end
                end
            end
            StWaddr: begin
                aw_done_d = aw_done_q | ((m_awvalid & m_awready) != 3'b000);
                w_done_d  = w_done_q | ((m_wvalid & m_wready) != 3'b000);
                if (timeout_hit) begin
                    hung_d  = hung_d | sel_oh;
                    bresp_d = RespSlverr;
                    state_d = StBresp;
                end else if (aw_done_d && w_done_d) begin
                    state_d = StWresp;
                end
            end
            StWresp: begin
                if ((m_bvalid & sel_oh) != 3'b000) begin
                    bresp_d = m_bresp[{sel_q, 1'b0} +: 2];
                    state_d = StBresp;
                end else if (timeout_hit) begin
                    hung_d  = hung_d | sel_oh;
                    bresp_d = RespSlverr;
                    state_d = StBresp;
                end
            end
            StBresp: begin
                if (s_bready) state_d = StIdle;
            end
            StRaddr: begin
                if (timeout_hit) begin
                    hung_d  = hung_d | sel_oh;
                    rresp_d = RespSlverr;
                    rdata_d = '0;
                    state_d = StRresp;
                end else if ((m_arvalid & m_arready) != 3'b000) begin
                    state_d = StRdata;
                end
            end
            StRdata: begin
                if ((m_rvalid & sel_oh) != 3'b000) begin
                    rdata_d = m_rdata[{sel_q, 5'd0} +: 32];
                    rresp_d = m_rresp[{sel_q, 1'b0} +: 2];
                    state_d = StRresp;
                end else if (timeout_hit) begin
                    hung_d  = hung_d | sel_oh;
                    rresp_d = RespSlverr;
                    rdata_d = '0;
                    state_d = StRresp;
                end
            end
            StRresp: begin
                if (s_rready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            user_q    <= '0;
            last_rd_q <= 1'b0;
            hung_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            timer_q   <= '0;
            bresp_q   <= RespOkay;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            user_q    <= user_d;
            last_rd_q <= last_rd_d;
            hung_q    <= hung_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            timer_q   <= timer_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_awready = grant_wr;
    assign s_wready  = grant_wr;
    assign s_arready = grant_rd;
    assign s_bvalid  = (state_q == StBresp);
    assign s_bresp   = bresp_q;
    assign s_rvalid  = (state_q == StRresp);
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;

    assign m_awvalid = (state_q == StWaddr && !aw_done_q) ? sel_oh : 3'b000;
    assign m_wvalid  = (state_q == StWaddr && !w_done_q) ? sel_oh : 3'b000;
    assign m_awaddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_bready  = hung_q | ((state_q == StWresp) ? sel_oh : 3'b000);
    assign m_arvalid = (state_q == StRaddr) ? sel_oh : 3'b000;
    assign m_araddr  = addr_q;
    assign m_aruser  = user_q;
    assign m_rready  = hung_q | ((state_q == StRdata) ? sel_oh : 3'b000);

endmodule

// File: tb/tb_axi_lite_target_router.sv
// Directed bench for axi_lite_target_router with simple zero-wait downstream slave models.
module tb_axi_lite_target_router;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb, s_aruser;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [2:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [2:0]  m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb, m_aruser;
    logic [5:0]  m_bresp, m_rresp;
    logic [95:0] m_rdata;

    int checks = 0;
    int errors = 0;

    // Slave model state and knobs
    logic [2:0]  sl_awok, sl_wok, sl_bv, sl_rv, arrdy_en, late_rv;
    logic [2:0]  aw_have, w_have, both;
    logic [31:0] sl_rdata [3];

    always #5 aclk = ~aclk;

    axi_lite_target_router #(.SEL_LSB(16), .TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .areset(areset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_aruser(s_aruser),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_aruser(m_aruser),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    assign aw_have   = sl_awok | (m_awvalid & m_awready);
    assign w_have    = sl_wok | (m_wvalid & m_wready);
    assign both      = aw_have & w_have;
    assign m_awready = 3'b111;
    assign m_wready  = 3'b111;
    assign m_arready = arrdy_en;
    assign m_bvalid  = sl_bv;
    assign m_bresp   = 6'b0;
    assign m_rvalid  = sl_rv | late_rv;
    assign m_rresp   = 6'b0;
    assign m_rdata   = {sl_rdata[2], sl_rdata[1], sl_rdata[0]};

    always @(posedge aclk) begin
        if (areset) begin
            sl_awok <= '0;
            sl_wok  <= '0;
            sl_bv   <= '0;
            sl_rv   <= '0;
        end else begin
            sl_awok <= aw_have & ~both;
            sl_wok  <= w_have & ~both;
            sl_bv   <= (sl_bv & ~m_bready) | both;
            sl_rv   <= (sl_rv & ~m_rready) | (m_arvalid & m_arready);
        end
    end

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
    endtask

    task automatic test_reset;
        areset = 1; clear_inputs();
        s_awaddr = 32'h0001_0000; s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'hF;
        s_araddr = 32'h0; s_aruser = 4'h0;
        arrdy_en = 3'b111; late_rv = 3'b000;
        sl_rdata[0] = 0; sl_rdata[1] = 0; sl_rdata[2] = 0;
        // Upstream requests held during reset must not be granted
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        step(); step();
        checks++; if ({s_awready, s_wready, s_arready} !== 3'b000) begin errors++;
            $display("FAIL rst_ready: got %b expected 000", {s_awready, s_wready, s_arready}); end
        checks++; if ({m_awvalid, m_wvalid, m_arvalid} !== 9'b0) begin errors++;
            $display("FAIL rst_mvalid: got %b expected 0", {m_awvalid, m_wvalid, m_arvalid}); end
        checks++; if ({m_bready, m_rready} !== 6'b0) begin errors++;
            $display("FAIL rst_mready: got %b expected 0", {m_bready, m_rready}); end
        checks++; if ({s_bvalid, s_rvalid} !== 2'b00) begin errors++;
            $display("FAIL rst_svalid: got %b expected 00", {s_bvalid, s_rvalid}); end
        checks++; if ({s_bresp, s_rresp, s_rdata} !== 36'h0) begin errors++;
            $display("FAIL rst_sresp: got %h expected 0", {s_bresp, s_rresp, s_rdata}); end
        checks++; if ({m_awaddr, m_wdata, m_wstrb, m_aruser} !== 72'h0) begin errors++;
            $display("FAIL rst_shared: got %h expected 0", {m_awaddr, m_wdata, m_wstrb, m_aruser}); end
        clear_inputs();
        areset = 0;
        step();
    endtask

    task automatic test_write_sel1;
        s_awaddr = 32'h0001_0004; s_wdata = 32'hA5A5_5A5A; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1;
        #1;
        checks++; if ({s_awready, s_wready} !== 2'b11) begin errors++;
            $display("FAIL wr_grant: got %b expected 11", {s_awready, s_wready}); end
        step();
        s_awvalid = 0; s_wvalid = 0;
        checks++; if ({m_awvalid, m_wvalid} !== 6'b010_010) begin errors++;
            $display("FAIL wr_mvalid_t1: got %b expected 010010", {m_awvalid, m_wvalid}); end
        checks++; if ({m_awaddr, m_wdata, m_wstrb} !== {32'h0001_0004, 32'hA5A5_5A5A, 4'hF}) begin
            errors++; $display("FAIL wr_mpayload: got %h", {m_awaddr, m_wdata, m_wstrb}); end
        step();
        checks++; if ({m_awvalid, m_wvalid, m_bready, s_bvalid} !== 10'b000_000_010_0) begin
            errors++; $display("FAIL wr_t2: got %b expected 0000000100",
                               {m_awvalid, m_wvalid, m_bready, s_bvalid}); end
        step();
        checks++; if ({s_bvalid, s_bresp} !== 3'b100) begin errors++;
            $display("FAIL wr_bresp_t3: got %b expected 100", {s_bvalid, s_bresp}); end
        s_bready = 1;
        step();
        s_bready = 0;
        checks++; if (s_bvalid !== 1'b0) begin errors++;
            $display("FAIL wr_bdone: got %b expected 0", s_bvalid); end
    endtask

    task automatic test_read_stall;
        sl_rdata[0] = 32'h1234_5678;
        s_araddr = 32'h0000_0010; s_aruser = 4'h9; s_arvalid = 1;
        #1;
        checks++; if (s_arready !== 1'b1) begin errors++;
            $display("FAIL rd_grant: got %b expected 1", s_arready); end
        step();
        s_arvalid = 0;
        checks++; if ({m_arvalid, m_araddr, m_aruser} !== {3'b001, 32'h0000_0010, 4'h9}) begin
            errors++; $display("FAIL rd_t1: got %h", {m_arvalid, m_araddr, m_aruser}); end
        step();
        checks++; if (m_rready !== 3'b001) begin errors++;
            $display("FAIL rd_rready_t2: got %b expected 001", m_rready); end
        step();
        checks++; if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b00, 32'h1234_5678}) begin
            errors++; $display("FAIL rd_t3: got %h", {s_rvalid, s_rresp, s_rdata}); end
        sl_rdata[0] = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if ({s_rvalid, s_rdata} !== {1'b1, 32'h1234_5678}) begin errors++;
                $display("FAIL rd_hold%0d: got %h expected 112345678", i, {s_rvalid, s_rdata});
            end
        end
        s_rready = 1;
        step();
        s_rready = 0;
        checks++; if (s_rvalid !== 1'b0) begin errors++;
            $display("FAIL rd_done: got %b expected 0", s_rvalid); end
    endtask

    task automatic test_alternate;
        logic       exp_rd;
        int         n;
        areset = 1; step(); areset = 0; step();
        s_bready = 1; s_rready = 1;
        for (int k = 0; k < 4; k++) begin
            exp_rd = (k % 2 == 0);
            s_awaddr = 32'h0001_0000; s_wdata = k; s_araddr = 32'h0000_0000;
            s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
            #1;
            checks++; if ({s_arready, s_awready, s_wready} !== (exp_rd ? 3'b100 : 3'b011)) begin
                errors++; $display("FAIL alt_grant%0d: got %b expected %b", k,
                    {s_arready, s_awready, s_wready}, exp_rd ? 3'b100 : 3'b011); end
            step();
            s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
            n = 0;
            while (!(s_bvalid || s_rvalid) && n < 20) begin step(); n++; end
            checks++; if ({s_rvalid, s_bvalid} !== (exp_rd ? 2'b10 : 2'b01)) begin errors++;
                $display("FAIL alt_resp%0d: got %b expected %b", k, {s_rvalid, s_bvalid},
                         exp_rd ? 2'b10 : 2'b01); end
            step();
        end
        s_bready = 0; s_rready = 0;
    endtask

    task automatic test_decerr;
        s_araddr = 32'h0003_0000; s_arvalid = 1;
        #1;
        checks++; if (s_arready !== 1'b1) begin errors++;
            $display("FAIL dec_rgrant: got %b expected 1", s_arready); end
        step();
        s_arvalid = 0;
        checks++; if (m_arvalid !== 3'b000) begin errors++;
            $display("FAIL dec_marvalid: got %b expected 000", m_arvalid); end
        checks++; if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b11, 32'h0}) begin errors++;
            $display("FAIL dec_rresp: got %h expected 300000000", {s_rvalid, s_rresp, s_rdata});
        end
        s_rready = 1; step(); s_rready = 0;
        s_awaddr = 32'h0003_0008; s_wdata = 32'h5555_AAAA; s_awvalid = 1; s_wvalid = 1;
        #1;
        step();
        s_awvalid = 0; s_wvalid = 0;
        checks++; if ({m_awvalid, m_wvalid} !== 6'b0) begin errors++;
            $display("FAIL dec_mwvalid: got %b expected 0", {m_awvalid, m_wvalid}); end
        checks++; if ({s_bvalid, s_bresp} !== 3'b111) begin errors++;
            $display("FAIL dec_bresp: got %b expected 111", {s_bvalid, s_bresp}); end
        s_bready = 1; step(); s_bready = 0;
    endtask

    task automatic test_timeout;
        arrdy_en = 3'b011;
        s_araddr = 32'h0002_0000; s_arvalid = 1;
        #1;
        step();
        s_arvalid = 0;
        for (int i = 1; i <= 16; i++) begin
            checks++; if ({m_arvalid, s_rvalid} !== 4'b100_0) begin errors++;
                $display("FAIL to_wait%0d: got %b expected 1000", i, {m_arvalid, s_rvalid}); end
            step();
        end
        checks++; if ({m_arvalid, s_rvalid, s_rresp, s_rdata} !== {3'b000, 1'b1, 2'b10, 32'h0})
        begin errors++; $display("FAIL to_resp: got %h", {m_arvalid, s_rvalid, s_rresp, s_rdata});
        end
        checks++; if (m_rready !== 3'b100) begin errors++;
            $display("FAIL to_hung_rready: got %b expected 100", m_rready); end
        s_rready = 1; step(); s_rready = 0;
        s_arvalid = 1;
        #1;
        step();
        s_arvalid = 0;
        checks++; if ({m_arvalid, s_rvalid, s_rresp} !== 6'b000_1_10) begin errors++;
            $display("FAIL to_fast_slverr: got %b expected 000110", {m_arvalid, s_rvalid, s_rresp});
        end
        s_rready = 1; step(); s_rready = 0;
        late_rv = 3'b100;
        step();
        late_rv = 3'b000;
        #1;
        checks++; if (m_rready !== 3'b000) begin errors++;
            $display("FAIL to_hung_clear: got %b expected 000", m_rready); end
        arrdy_en = 3'b111; sl_rdata[2] = 32'hCAFE_0002;
        s_arvalid = 1;
        #1;
        step();
        s_arvalid = 0;
        checks++; if (m_arvalid !== 3'b100) begin errors++;
            $display("FAIL to_reissue: got %b expected 100", m_arvalid); end
        step(); step();
        checks++; if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b00, 32'hCAFE_0002}) begin
            errors++; $display("FAIL to_ok: got %h", {s_rvalid, s_rresp, s_rdata}); end
        s_rready = 1; step(); s_rready = 0;
    endtask

    task automatic test_reset_mid;
        int lat;
        s_awaddr = 32'h0001_0008; s_wdata = 32'h1111_2222; s_wstrb = 4'h3;
        s_awvalid = 1; s_wvalid = 1;
        #1;
        step();
        s_awvalid = 0; s_wvalid = 0;
        step();
        checks++; if (m_bready !== 3'b010) begin errors++;
            $display("FAIL rm_in_wresp: got %b expected 010", m_bready); end
        areset = 1;
        step();
        checks++; if ({s_bvalid, m_bready, m_awvalid, m_wvalid, s_bresp} !== 12'b0) begin
            errors++; $display("FAIL rm_ctrl: got %b expected 0",
                               {s_bvalid, m_bready, m_awvalid, m_wvalid, s_bresp}); end
        checks++; if ({m_awaddr, m_wdata, m_wstrb} !== 68'h0) begin errors++;
            $display("FAIL rm_shared: got %h expected 0", {m_awaddr, m_wdata, m_wstrb}); end
        areset = 0;
        step();
        s_awaddr = 32'h0000_0020; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1;
        #1;
        step();
        lat = 1;
        s_awvalid = 0; s_wvalid = 0;
        while (!s_bvalid && lat < 40) begin step(); lat++; end
        checks++; if (lat !== 3) begin errors++;
            $display("FAIL rm_latency: got %0d expected 3", lat); end
        checks++; if ({s_bvalid, s_bresp} !== 3'b100) begin errors++;
            $display("FAIL rm_bresp: got %b expected 100", {s_bvalid, s_bresp}); end
        s_bready = 1; step(); s_bready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_sel1();
        test_read_stall();
        test_alternate();
        test_decerr();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
